// File: rtl/dmem_pkg.sv
// Shared types for the data-memory port arbiter: port identifiers, arbitration
// states, the request bundle routed to memory and the read-return tag.
package dmem_pkg;

   typedef enum logic {
      PORT_P0 = 1'b0,
      PORT_P1 = 1'b1
   } port_id_e;

   typedef enum logic {
      PRIO_P0 = 1'b0,
      PRIO_P1 = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } dmem_req_t;

   typedef struct packed {
      logic     valid;
      port_id_e port;
   } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line of read tags, one stage per cycle of memory read latency. The tag
// leaving the last stage lines up with the read data coming back from memory.
module rd_tag_pipe
   import dmem_pkg::*;
#(
   parameter int RD_LAT = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  rd_tag_t push_tag,
   output rd_tag_t out_tag
);

   localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, port: PORT_P0};

   rd_tag_t stage [RD_LAT];

   generate
      for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            // First stage captures the tag of whatever was issued this cycle.
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  stage[gi] <= TAG_IDLE;
               end else begin
                  stage[gi] <= push_tag;
               end
            end
         end else begin : g_body
            // Later stages just shift; reset drops every in-flight read.
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  stage[gi] <= TAG_IDLE;
               end else begin
                  stage[gi] <= stage[gi-1];
               end
            end
         end
      end
   endgenerate

   assign out_tag = stage[RD_LAT-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port data memory. The pipeline (port 0)
// normally wins conflicts; the debug port (port 1) is promoted after being
// refused MAX_WAIT times. Read data is steered back by a tag delay line.
module dmem_port_arbiter
   import dmem_pkg::*;
#(
   parameter int RD_LAT   = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        p0_req_i,
   input  logic        p0_we_i,
   input  logic [31:0] p0_addr_i,
   input  logic [31:0] p0_wdata_i,
   input  logic [3:0]  p0_be_i,
   output logic        p0_gnt_o,
   output logic        p0_rvalid_o,
   output logic [31:0] p0_rdata_o,
   output logic        p0_stall_o,
   input  logic        p1_req_i,
   input  logic        p1_we_i,
   input  logic [31:0] p1_addr_i,
   input  logic [31:0] p1_wdata_i,
   input  logic [3:0]  p1_be_i,
   output logic        p1_gnt_o,
   output logic        p1_rvalid_o,
   output logic [31:0] p1_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   input  logic [31:0] mem_rdata_i
);

   localparam int             CNT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   arb_state_e       state, state_next;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
   logic             gnt0, gnt1;
   dmem_req_t        sel_req;
   rd_tag_t          push_tag, out_tag;

   // Grant decision; nothing is granted while reset is held.
   always_comb begin
      gnt1 = ~rst_i & p1_req_i & (~p0_req_i | (state == PRIO_P1));
      gnt0 = ~rst_i & p0_req_i & ~gnt1;
   end

   // Starvation counter and priority flip; a p1 grant clears the count even
   // on the cycle it would otherwise saturate.
   always_comb begin
      wait_cnt_next = wait_cnt;
      state_next    = state;
      if (gnt1) begin
         wait_cnt_next = '0;
      end else if (p1_req_i && (wait_cnt != CNT_MAX)) begin
         wait_cnt_next = wait_cnt + CNT_W'(1);
      end
      case (state)
         PRIO_P0: if (wait_cnt_next == CNT_MAX) state_next = PRIO_P1;
         PRIO_P1: if (gnt1)                     state_next = PRIO_P0;
         default:                               state_next = PRIO_P0;
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= PRIO_P0;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // Route the granted port's request to memory; all-zero when idle.
   always_comb begin
      sel_req = '0;
      if (gnt0) begin
         sel_req = '{we: p0_we_i, addr: p0_addr_i, wdata: p0_wdata_i, be: p0_be_i};
      end else if (gnt1) begin
         sel_req = '{we: p1_we_i, addr: p1_addr_i, wdata: p1_wdata_i, be: p1_be_i};
      end
   end

   assign mem_req_o   = gnt0 | gnt1;
   assign mem_we_o    = sel_req.we;
   assign mem_addr_o  = sel_req.addr;
   assign mem_wdata_o = sel_req.wdata;
   assign mem_be_o    = sel_req.be;

   assign p0_gnt_o   = gnt0;
   assign p1_gnt_o   = gnt1;
   assign p0_stall_o = ~rst_i & p0_req_i & ~gnt0;

   // Only granted loads produce a response.
   always_comb begin
      push_tag.valid = (gnt0 | gnt1) & ~sel_req.we;
      push_tag.port  = gnt1 ? PORT_P1 : PORT_P0;
   end

   rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_tag_pipe (
      .clk      (clk_i),
      .rst      (rst_i),
      .push_tag (push_tag),
      .out_tag  (out_tag)
   );

   // Steer returning read data to the port that issued it.
   always_comb begin
      p0_rvalid_o = out_tag.valid & (out_tag.port == PORT_P0);
      p1_rvalid_o = out_tag.valid & (out_tag.port == PORT_P1);
      p0_rdata_o  = p0_rvalid_o ? mem_rdata_i : 32'h0;
      p1_rdata_o  = p1_rvalid_o ? mem_rdata_i : 32'h0;
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a latency-accurate memory model, scenario tasks
// with inline grant/mux checks, and a scoreboard for read responses.
module tb_dmem_port_arbiter;

   localparam int RD_LAT   = 2;
   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i;
   logic [31:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
   logic [3:0]  p0_be_i, p1_be_i;
   logic        p0_gnt_o, p0_rvalid_o, p0_stall_o, p1_gnt_o, p1_rvalid_o;
   logic [31:0] p0_rdata_o, p1_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_be_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int          port;
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   dmem_port_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i),
      .p0_wdata_i(p0_wdata_i), .p0_be_i(p0_be_i), .p0_gnt_o(p0_gnt_o),
      .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o), .p0_stall_o(p0_stall_o),
      .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i),
      .p1_wdata_i(p1_wdata_i), .p1_be_i(p1_be_i), .p1_gnt_o(p1_gnt_o),
      .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
   );

   // Memory contents: fixed function of address, with the one word the spec names.
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return {a[15:0] ^ 16'hA5A5, ~a[15:0]};
   endfunction

   // Memory model: read data appears RD_LAT cycles after the issue cycle.
   logic [31:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      rd_pipe[0] <= (mem_req_o && !mem_we_o) ? mem_fn(mem_addr_o) : 32'h0;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata_i = rd_pipe[RD_LAT-1];

   // Response monitor: every rvalid must match the oldest expected load.
   always @(negedge clk) begin
      exp_t e;
      checks++;
      if (!p0_rvalid_o && p0_rdata_o !== 32'h0) begin
         failures++;
         $display("FAIL idle_rdata0 cyc=%0d got=%h want=0", cyc, p0_rdata_o);
      end
      checks++;
      if (!p1_rvalid_o && p1_rdata_o !== 32'h0) begin
         failures++;
         $display("FAIL idle_rdata1 cyc=%0d got=%h want=0", cyc, p1_rdata_o);
      end
      if (p0_rvalid_o || p1_rvalid_o) begin
         checks++;
         if (p0_rvalid_o && p1_rvalid_o) begin
            failures++;
            $display("FAIL dual_rvalid cyc=%0d got=both want=one", cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end else if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_rvalid cyc=%0d p0=%0b p1=%0b want=none",
                     cyc, p0_rvalid_o, p1_rvalid_o);
         end else begin
            e = exp_q.pop_front();
            if ((p1_rvalid_o ? 1 : 0) !== e.port || cyc !== e.due ||
                (p1_rvalid_o ? p1_rdata_o : p0_rdata_o) !== e.data) begin
               failures++;
               $display("FAIL rsp cyc=%0d got port=%0d data=%h want port=%0d data=%h due=%0d",
                        cyc, p1_rvalid_o ? 1 : 0, p1_rvalid_o ? p1_rdata_o : p0_rdata_o,
                        e.port, e.data, e.due);
            end else begin
               $display("rsp  cyc=%0d port=%0d data=%h", cyc, e.port, e.data);
            end
         end
      end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
         checks++;
         failures++;
         e = exp_q.pop_front();
         $display("FAIL missing_rvalid cyc=%0d got=none want port=%0d due=%0d",
                  cyc, e.port, e.due);
      end
   end

   task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic [3:0] b0,
                        input logic r1, input logic w1, input logic [31:0] a1,
                        input logic [31:0] d1, input logic [3:0] b1);
      p0_req_i = r0; p0_we_i = w0; p0_addr_i = a0; p0_wdata_i = d0; p0_be_i = b0;
      p1_req_i = r1; p1_we_i = w1; p1_addr_i = a1; p1_wdata_i = d1; p1_be_i = b1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic exp_load(input int port, input logic [31:0] addr);
      exp_t e;
      e.port = port;
      e.data = mem_fn(addr);
      e.due  = cyc + RD_LAT;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      drive(1, 0, 32'h40, 0, 4'hF, 1, 0, 32'h44, 0, 4'hF);
      repeat (3) begin
         @(negedge clk); #1;
         checks++;
         if ({p0_gnt_o, p1_gnt_o, p0_stall_o, mem_req_o, mem_we_o} !== 5'b0 ||
             mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || mem_be_o !== 4'h0) begin
            failures++;
            $display("FAIL reset_outputs cyc=%0d got gnt=%b%b stall=%b req=%b we=%b addr=%h want all 0",
                     cyc, p0_gnt_o, p1_gnt_o, p0_stall_o, mem_req_o, mem_we_o, mem_addr_o);
         end else $display("reset cyc=%0d outputs idle", cyc);
      end
      @(negedge clk);
      rst_i = 1'b0;
      idle();
   endtask

   task automatic test_p0_load();
      @(negedge clk);
      drive(1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (p0_gnt_o !== 1'b1 || p1_gnt_o !== 1'b0 || mem_req_o !== 1'b1 ||
          mem_we_o !== 1'b0 || mem_addr_o !== 32'h10 || p0_stall_o !== 1'b0) begin
         failures++;
         $display("FAIL p0_load_issue got gnt=%b%b req=%b we=%b addr=%h want gnt=10 req=1 we=0 addr=10",
                  p0_gnt_o, p1_gnt_o, mem_req_o, mem_we_o, mem_addr_o);
      end else $display("issue cyc=%0d port=0 load addr=%h", cyc, mem_addr_o);
      exp_load(0, 32'h10);
      @(negedge clk);
      idle();
      repeat (RD_LAT + 2) @(negedge clk);
   endtask

   task automatic test_arbitration();
      logic [31:0] a0 = 32'h100;
      logic [31:0] a1 = 32'h200;
      logic        want1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         drive(1, 0, a0, 0, 4'hF, 1, 0, a1, 0, 4'hF);
         #1;
         want1 = (k == 4);
         checks++;
         if (p0_gnt_o !== !want1 || p1_gnt_o !== want1 || p0_stall_o !== want1 ||
             mem_addr_o !== (want1 ? a1 : a0)) begin
            failures++;
            $display("FAIL arb_k%0d got gnt=%b%b stall=%b addr=%h want gnt=%b%b stall=%b addr=%h",
                     k, p0_gnt_o, p1_gnt_o, p0_stall_o, mem_addr_o,
                     !want1, want1, want1, want1 ? a1 : a0);
         end else $display("arb  cyc=%0d k=%0d grant=p%0d", cyc, k, want1 ? 1 : 0);
         if (want1) begin exp_load(1, a1); a1 += 4; end
         else       begin exp_load(0, a0); a0 += 4; end
      end
      @(negedge clk);
      idle();
      repeat (RD_LAT + 2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
      int          ports [3] = '{0, 1, 0};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (ports[k] == 0) drive(1, 0, addrs[k], 0, 4'hF, 0, 0, 0, 0, 0);
         else               drive(0, 0, 0, 0, 0, 1, 0, addrs[k], 0, 4'hF);
         #1;
         checks++;
         if (p0_gnt_o !== (ports[k] == 0) || p1_gnt_o !== (ports[k] == 1) ||
             mem_addr_o !== addrs[k]) begin
            failures++;
            $display("FAIL b2b_issue%0d got gnt=%b%b addr=%h want port=%0d addr=%h",
                     k, p0_gnt_o, p1_gnt_o, mem_addr_o, ports[k], addrs[k]);
         end else $display("issue cyc=%0d port=%0d load addr=%h", cyc, ports[k], addrs[k]);
         exp_load(ports[k], addrs[k]);
      end
      @(negedge clk);
      idle();
      repeat (RD_LAT + 2) @(negedge clk);
   endtask

   task automatic test_store();
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h1234, 4'hF);
      #1;
      checks++;
      if (p1_gnt_o !== 1'b1 || mem_req_o !== 1'b1 || mem_we_o !== 1'b1 ||
          mem_addr_o !== 32'h20 || mem_wdata_o !== 32'h1234 || mem_be_o !== 4'hF) begin
         failures++;
         $display("FAIL store_issue got gnt1=%b req=%b we=%b addr=%h wdata=%h be=%h want 1 1 1 20 1234 f",
                  p1_gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o);
      end else $display("store cyc=%0d port=1 addr=%h wdata=%h", cyc, mem_addr_o, mem_wdata_o);
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin
         failures++;
         $display("FAIL store_one_cycle got req=%b we=%b want 0 0", mem_req_o, mem_we_o);
      end
      repeat (RD_LAT + 2) @(negedge clk);
   endtask

   task automatic test_reset_midflight();
      logic want1;
      // Two conflicting stores leave the starvation counter part-way up.
      repeat (2) begin
         @(negedge clk);
         drive(1, 1, 32'h80, 32'h1, 4'hF, 1, 1, 32'h84, 32'h2, 4'hF);
      end
      @(negedge clk);
      drive(1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_i = 1'b1;
      idle();
      #1;
      checks++;
      if (p0_gnt_o !== 1'b0 || mem_req_o !== 1'b0 || p0_rvalid_o !== 1'b0) begin
         failures++;
         $display("FAIL midrst_outputs got gnt0=%b req=%b rvalid0=%b want 0 0 0",
                  p0_gnt_o, mem_req_o, p0_rvalid_o);
      end else $display("reset cyc=%0d asserted with load in flight", cyc);
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      repeat (4) begin
         @(negedge clk); #1;
         checks++;
         if (p0_rvalid_o !== 1'b0 || p1_rvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL dropped_read got rvalid=%b%b want 00", p0_rvalid_o, p1_rvalid_o);
         end
      end
      // Counter and FSM must start from scratch: p0 wins 4 times, p1 on the 5th.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive(1, 1, 32'h90, 32'h3, 4'h3, 1, 1, 32'h94, 32'h4, 4'hC);
         #1;
         want1 = (k == 4);
         checks++;
         if (p0_gnt_o !== !want1 || p1_gnt_o !== want1) begin
            failures++;
            $display("FAIL postrst_arb_k%0d got gnt=%b%b want gnt=%b%b",
                     k, p0_gnt_o, p1_gnt_o, !want1, want1);
         end else $display("arb  cyc=%0d k=%0d grant=p%0d", cyc, k, want1 ? 1 : 0);
      end
      @(negedge clk);
      idle();
      repeat (RD_LAT + 2) @(negedge clk);
   endtask

   initial begin
      rst_i = 1'b1;
      idle();
      test_reset();
      test_p0_load();
      test_arbitration();
      test_back_to_back();
      test_store();
      test_reset_midflight();
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got pending=%0d want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
